strided_buffer_seq: RTL and testbench
=====================================

// Module: strided_buffer_seq
// PURPOSE
//  Per-layer sequencer for the strided input buffer: accepts a shape command, clears the buffer,
//  gates the DDR read stream into it word by word, checks the word count against the shape,
//  then fires the buffer's compute start and waits for the DSP array to finish before accepting
//  the next command. Sits between the DDR read DMA stream and the strided buffer/DSP datapath.
// PARAMETERS
//  DATA_WIDTH   64   stream/buffer word width
//  B_DSHAPE     48   shape word: {W[47:32], H[31:16], C[15:0]}
//  B_COORD      8    coordinate width of buffer; H,W must be <= 2**B_COORD-1
//  B_CNT        26   word counter width (holds 1023*255*255)
//  LD_TIMEOUT   16   cycles allowed in WAIT_LD for buf_done_ld
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous reset, active-high
//  abort        in   1           sync abort, any state
//  cmd_valid    in   1           shape command valid
//  cmd_ready    out  1           high only in IDLE
//  cmd_dshape   in   B_DSHAPE    {W,H,C}
//  s_tvalid     in   1           input stream valid
//  s_tready     out  1           input stream ready
//  s_tdata      in   DATA_WIDTH  input stream data
//  s_tlast      in   1           last word of layer
//  buf_clr      out  1           buffer clear
//  buf_we       out  1           buffer write enable
//  buf_di       out  DATA_WIDTH  buffer write data
//  buf_dshape   out  B_DSHAPE    latched shape to buffer
//  buf_start    out  1           one-cycle compute start
//  buf_done_ld  in   1           buffer reports load complete
//  cmp_done     in   1           DSP array finished compute pass
//  busy         out  1           state != IDLE
//  done         out  1           one-cycle layer-complete pulse
//  err          out  1           one-cycle error pulse
//  err_code     out  2           0 none,1 shape,2 tlast,3 ld timeout; holds until next accepted cmd
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cmd_ready=1; counters, buf_dshape, err_code cleared.
//  Command accepted on cmd_valid&cmd_ready: latch dshape; n_wrap=C>>6 (10b);
//   total=n_wrap*H*W in B_CNT bits, registered (1 cycle, CHECK state).
//  CHECK: n_wrap==0, H==0, W==0, H>255 or W>255 -> ERR(code 1); else CLR.
//  CLR: buf_clr=1 for exactly 2 cycles, then LOAD; wcnt=0.
//  LOAD: s_tready = (wcnt<total). Handshake = s_tvalid&s_tready.
//   buf_we/buf_di registered: handshake in cycle t -> buf_we=1, buf_di=s_tdata in t+1.
//   wcnt increments per handshake. Handshake with wcnt==total-1: s_tlast must be 1 -> WAIT_LD;
//   s_tlast=0 -> ERR(code 2). s_tlast=1 with wcnt<total-1 -> ERR(code 2), word still written.
//   s_tvalid stalls are unlimited in LOAD (no timeout).
//  WAIT_LD: s_tready=0; wait buf_done_ld=1 -> START; if LD_TIMEOUT cycles elapse -> ERR(code 3).
//  START: buf_start=1 one cycle -> COMPUTE.
//  COMPUTE: wait cmp_done=1 -> DONE. cmp_done in any other state is ignored.
//  DONE: done=1 one cycle -> IDLE.
//  ERR: err=1 and buf_clr=1 one cycle -> IDLE; err_code set on ERR entry.
//  abort (priority below rst, above all else): next state IDLE, buf_clr=1 one cycle, no done/err,
//   pending buf_we of the same cycle suppressed, s_tready=0 immediately (combinational).
//  cmd_valid outside IDLE ignored (cmd_ready=0). buf_dshape stable from accept to next accept.
//  rst mid-LOAD: all state dropped; buffer contents not cleared by this block until next CLR.
// TESTING
//  C=128,H=4,W=5: 40 words, no stalls -> buf_clr 2 cycles, 40 buf_we, buf_start 1 cycle, done after cmp_done.
//  Same shape, random s_tvalid gaps -> buf_di sequence equals s_tdata order, exactly 40 writes.
//  C=32 (n_wrap=0) -> err=1, err_code=1, no buf_we, no buf_start, cmd_ready back next cycle.
//  C=64,H=2,W=2: tlast on word 2 -> err_code=2 after 2 writes; no tlast on word 4 -> err_code=2.
//  buf_done_ld held 0 after load -> err_code=3 exactly 16 cycles after WAIT_LD entry.
//  abort asserted mid-LOAD (word 10 of 40) -> no further buf_we, buf_clr pulse, IDLE, no done/err.

Source files
------------

// File: rtl/strided_buffer_seq.sv
// Per-layer sequencer for the strided input buffer: accepts a shape, clears the buffer,
// gates the DDR read stream into it, checks the word count, then runs one compute pass.
module strided_buffer_seq #(
   parameter int DATA_WIDTH = 64,
   parameter int B_DSHAPE   = 48,
   parameter int B_COORD    = 8,
   parameter int B_CNT      = 26,
   parameter int LD_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  abort,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [B_DSHAPE-1:0]   cmd_dshape,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic                  buf_clr,
   output logic                  buf_we,
   output logic [DATA_WIDTH-1:0] buf_di,
   output logic [B_DSHAPE-1:0]   buf_dshape,
   output logic                  buf_start,
   input  logic                  buf_done_ld,
   input  logic                  cmp_done,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam int FW   = B_DSHAPE / 3;
   localparam int NW_W = FW - 6;
   localparam int TO_W = $clog2(LD_TIMEOUT + 1);
   localparam logic [FW-1:0]   COORD_MAX = FW'((1 << B_COORD) - 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(LD_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_CLR, S_LOAD, S_WAIT_LD, S_START, S_COMPUTE, S_DONE, S_ERR
   } state_t;

   state_t                state_q, state_d;
   logic [B_DSHAPE-1:0]   dshape_q;
   logic [B_CNT-1:0]      total_q, total_d;
   logic [B_CNT-1:0]      wcnt_q;
   logic                  clr_ph_q;
   logic [TO_W-1:0]       to_q;
   logic [1:0]            err_code_q, err_code_d;
   logic                  cmd_ready_q, busy_q, buf_clr_q, buf_start_q, done_q, err_q;
   logic                  buf_we_q;
   logic [DATA_WIDTH-1:0] buf_di_q;

   logic [NW_W-1:0] n_wrap;
   logic [FW-1:0]   shp_h, shp_w;
   logic            shape_bad, hs, last_word;

   assign n_wrap = dshape_q[FW-1:6];
   assign shp_h  = dshape_q[2*FW-1:FW];
   assign shp_w  = dshape_q[3*FW-1:2*FW];

   assign total_d = B_CNT'(n_wrap) * B_CNT'(shp_h[B_COORD-1:0]) * B_CNT'(shp_w[B_COORD-1:0]);
   assign shape_bad = (n_wrap == '0) || (shp_h == '0) || (shp_w == '0) ||
                      (shp_h > COORD_MAX) || (shp_w > COORD_MAX);

   // Abort must drop ready in the same cycle so no word slips in behind it
   assign s_tready  = (state_q == S_LOAD) && (wcnt_q < total_q) && !abort;
   assign hs        = s_tvalid && s_tready;
   assign last_word = (wcnt_q == total_q - B_CNT'(1));

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: if (cmd_valid) begin
               state_d    = S_CHECK;
               err_code_d = 2'd0;
            end
            S_CHECK: if (shape_bad) begin
               state_d    = S_ERR;
               err_code_d = 2'd1;
            end else begin
               state_d = S_CLR;
            end
            S_CLR: if (clr_ph_q) state_d = S_LOAD;
            S_LOAD: if (hs) begin
               if (last_word && s_tlast) begin
                  state_d = S_WAIT_LD;
               end else if (last_word || s_tlast) begin
                  state_d    = S_ERR;
                  err_code_d = 2'd2;
               end
            end
            S_WAIT_LD: if (buf_done_ld) begin
               state_d = S_START;
            end else if (to_q == TO_LAST) begin
               state_d    = S_ERR;
               err_code_d = 2'd3;
            end
            S_START:   state_d = S_COMPUTE;
            S_COMPUTE: if (cmp_done) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         dshape_q    <= '0;
         total_q     <= '0;
         wcnt_q      <= '0;
         clr_ph_q    <= 1'b0;
         to_q        <= '0;
         err_code_q  <= 2'd0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         buf_clr_q   <= 1'b0;
         buf_start_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_di_q    <= '0;
      end else begin
         state_q    <= state_d;
         err_code_q <= err_code_d;
         if (state_q == S_IDLE && cmd_valid && !abort) dshape_q <= cmd_dshape;
         if (state_q == S_CHECK) total_q <= total_d;
         clr_ph_q <= (state_q == S_CLR) && !clr_ph_q;
         if (state_q == S_CLR)  wcnt_q <= '0;
         else if (hs)           wcnt_q <= wcnt_q + B_CNT'(1);
         to_q <= (state_q == S_WAIT_LD) ? to_q + TO_W'(1) : '0;
         // Outputs are registered from the next state so they line up with the state they mark
         cmd_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         buf_clr_q   <= abort || (state_d == S_CLR) || (state_d == S_ERR);
         buf_start_q <= (state_d == S_START);
         done_q      <= (state_d == S_DONE);
         err_q       <= (state_d == S_ERR);
         buf_we_q    <= hs;
         if (hs) buf_di_q <= s_tdata;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign buf_clr    = buf_clr_q;
   assign buf_we     = buf_we_q && !abort;
   assign buf_di     = buf_di_q;
   assign buf_dshape = dshape_q;
   assign buf_start  = buf_start_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_strided_buffer_seq.sv
// Directed bench for strided_buffer_seq: normal load, stalls, shape/tlast/timeout errors,
// abort and reset mid-load.
module tb_strided_buffer_seq;

   logic        clk = 1'b0;
   logic        rst, abort, cmd_valid, cmd_ready;
   logic [47:0] cmd_dshape, buf_dshape;
   logic        s_tvalid, s_tready, s_tlast;
   logic [63:0] s_tdata, buf_di;
   logic        buf_clr, buf_we, buf_start, buf_done_ld, cmp_done, busy, done, err;
   logic [1:0]  err_code;

   int n_cmp = 0;
   int n_mis = 0;

   strided_buffer_seq dut (
      .clk(clk), .rst(rst), .abort(abort),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dshape(cmd_dshape),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .buf_clr(buf_clr), .buf_we(buf_we), .buf_di(buf_di), .buf_dshape(buf_dshape),
      .buf_start(buf_start), .buf_done_ld(buf_done_ld), .cmp_done(cmp_done),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Output monitor, sampled on the falling edge
   int          cyc = 0, we_cnt = 0, clr_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
   int          last_we_cyc = 0, err_cyc = 0;
   logic [63:0] di_q[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (buf_we) begin
         we_cnt = we_cnt + 1;
         last_we_cyc = cyc;
         di_q.push_back(buf_di);
      end
      if (buf_clr)   clr_cnt   = clr_cnt + 1;
      if (buf_start) start_cnt = start_cnt + 1;
      if (done)      done_cnt  = done_cnt + 1;
      if (err) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_mis = n_mis + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [47:0] shp);
      cmd_valid  = 1'b1;
      cmd_dshape = shp;
      step();
      cmd_valid  = 1'b0;
   endtask

   bit tmo = 1'b0;
   task automatic push_word(input logic [63:0] d, input logic last);
      int k = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      while (!s_tready && k < 200) begin
         step();
         k++;
      end
      if (!s_tready) tmo = 1'b1;
      step();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   int          b_we, b_clr, b_st, b_dn, b_er, b_di, bad;
   logic [63:0] exp_d[$];

   task automatic snap();
      b_we = we_cnt; b_clr = clr_cnt; b_st = start_cnt; b_dn = done_cnt; b_er = err_cnt;
      b_di = di_q.size();
   endtask

   localparam logic [47:0] SHP40 = {16'd5, 16'd4, 16'd128};
   localparam logic [47:0] SHP4  = {16'd2, 16'd2, 16'd64};

   initial begin
      rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_dshape = '0;
      s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; buf_done_ld = 1'b0; cmp_done = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_clr", buf_clr, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_dshape", buf_dshape, 0);
      chk("rst_err_code", err_code, 0);

      // cmp_done in IDLE is ignored
      snap();
      cmp_done = 1'b1; step(); cmp_done = 1'b0; step(); step();
      chk("idle_cmp_done", done_cnt - b_dn, 0);

      // 40 words, no stalls
      snap();
      exp_d.delete();
      send_cmd(SHP40);
      chk("t1_busy", busy, 1);
      for (int i = 0; i < 40; i++) begin
         exp_d.push_back(64'hA5A5_0000_0000_0000 + 64'(i));
         push_word(exp_d[i], i == 39);
      end
      buf_done_ld = 1'b1; step(); buf_done_ld = 1'b0;
      repeat (5) step();
      chk("t1_start_cnt", start_cnt - b_st, 1);
      chk("t1_no_early_done", done_cnt - b_dn, 0);
      cmp_done = 1'b1; step(); cmp_done = 1'b0;
      repeat (3) step();
      chk("t1_we_cnt", we_cnt - b_we, 40);
      chk("t1_clr_cnt", clr_cnt - b_clr, 2);
      chk("t1_done_cnt", done_cnt - b_dn, 1);
      chk("t1_err_cnt", err_cnt - b_er, 0);
      chk("t1_dshape", buf_dshape, SHP40);
      chk("t1_cmd_ready", cmd_ready, 1);
      bad = 0;
      for (int i = 0; i < 40; i++) if (di_q[b_di + i] !== exp_d[i]) bad++;
      chk("t1_di_seq", bad, 0);

      // Same shape with random valid gaps
      snap();
      exp_d.delete();
      send_cmd(SHP40);
      for (int i = 0; i < 40; i++) begin
         exp_d.push_back({$urandom, $urandom});
         repeat ($urandom_range(0, 3)) step();
         push_word(exp_d[i], i == 39);
      end
      buf_done_ld = 1'b1; step(); buf_done_ld = 1'b0;
      repeat (3) step();
      cmp_done = 1'b1; step(); cmp_done = 1'b0;
      repeat (3) step();
      chk("t2_we_cnt", we_cnt - b_we, 40);
      chk("t2_done_cnt", done_cnt - b_dn, 1);
      bad = 0;
      for (int i = 0; i < 40; i++) if (di_q[b_di + i] !== exp_d[i]) bad++;
      chk("t2_di_seq", bad, 0);

      // n_wrap == 0 -> shape error, ready again the cycle after err
      snap();
      send_cmd({16'd5, 16'd4, 16'd32});
      step();
      chk("t3_err", err, 1);
      chk("t3_err_code", err_code, 1);
      chk("t3_cmd_ready_err", cmd_ready, 0);
      step();
      chk("t3_cmd_ready_back", cmd_ready, 1);
      repeat (3) step();
      chk("t3_we_cnt", we_cnt - b_we, 0);
      chk("t3_start_cnt", start_cnt - b_st, 0);
      chk("t3_err_cnt", err_cnt - b_er, 1);

      // Early tlast on word 2 of 4
      snap();
      send_cmd(SHP4);
      push_word(64'h11, 1'b0);
      push_word(64'h22, 1'b1);
      repeat (4) step();
      chk("t4a_we_cnt", we_cnt - b_we, 2);
      chk("t4a_err_cnt", err_cnt - b_er, 1);
      chk("t4a_err_code", err_code, 2);
      chk("t4a_start_cnt", start_cnt - b_st, 0);

      // Missing tlast on word 4 of 4
      snap();
      send_cmd(SHP4);
      chk("t4b_code_cleared", err_code, 0);
      for (int i = 0; i < 4; i++) push_word(64'(i), 1'b0);
      repeat (4) step();
      chk("t4b_we_cnt", we_cnt - b_we, 4);
      chk("t4b_err_cnt", err_cnt - b_er, 1);
      chk("t4b_err_code", err_code, 2);

      // Load-done timeout
      snap();
      send_cmd(SHP4);
      for (int i = 0; i < 4; i++) push_word(64'(i), i == 3);
      repeat (25) step();
      chk("t5_err_cnt", err_cnt - b_er, 1);
      chk("t5_err_code", err_code, 3);
      chk("t5_err_delay", err_cyc - last_we_cyc, 16);
      chk("t5_start_cnt", start_cnt - b_st, 0);

      // Abort after word 10 of 40
      snap();
      send_cmd(SHP40);
      for (int i = 0; i < 10; i++) push_word(64'(i), 1'b0);
      step();
      abort = 1'b1; s_tvalid = 1'b1; s_tdata = 64'hDEAD;
      #1;
      chk("t6_tready_abort", s_tready, 0);
      step();
      abort = 1'b0;
      chk("t6_clr_pulse", buf_clr, 1);
      chk("t6_cmd_ready", cmd_ready, 1);
      repeat (10) step();
      s_tvalid = 1'b0;
      step();
      chk("t6_we_cnt", we_cnt - b_we, 10);
      chk("t6_clr_cnt", clr_cnt - b_clr, 3);
      chk("t6_done_cnt", done_cnt - b_dn, 0);
      chk("t6_err_cnt", err_cnt - b_er, 0);

      // Reset mid-load
      send_cmd(SHP4);
      push_word(64'h5, 1'b0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t7_cmd_ready", cmd_ready, 1);
      chk("t7_dshape", buf_dshape, 0);
      chk("t7_busy", busy, 0);

      chk("tready_timeout", tmo, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
